// File: rtl/seg7_scan_if.sv
// Bus between the register-select mux and the seven-segment scan driver.
// The master supplies the value, load strobe and decimal points. The slave
// returns the registered anode, segment and decimal-point drives.
interface seg7_scan_if;
   logic [15:0] value;
   logic        load;
   logic [3:0]  dp_en;
   logic [3:0]  AN;
   logic [6:0]  BCD;
   logic        DP;

   modport master (
      output value, load, dp_en,
      input  AN, BCD, DP
   );

   modport slave (
      input  value, load, dp_en,
      output AN, BCD, DP
   );
endinterface

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit hex display driver for a common-anode display.
// A load strobe captures the value into a shadow register. The shadow is
// committed to the displayed copy only at a frame boundary (digit 3 -> 0), so
// a frame never shows a mix of old and new digits. Each digit slot opens with
// BLANK_CYC cycles with all anodes off, which suppresses ghosting between digits.
module seg7_scan_display #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500,
   parameter int BLANK_LZ  = 1
) (
   input  logic   clk,
   input  logic   reset,
   seg7_scan_if.slave bus
);

   localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SCAN_DIV - 1);
   localparam logic [TICK_W-1:0] BLANK_TICK = TICK_W'(BLANK_CYC);
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   logic [TICK_W-1:0] tick;
   logic [1:0]        digit;
   logic [15:0]       shadow;
   logic [15:0]       shown;
   logic              pending;

   logic       slot_end;
   logic       frame_end;
   logic       in_blank;
   logic       lz_blank;
   logic [3:0] nibble;
   logic [3:0] an_nxt;
   logic [6:0] bcd_nxt;
   logic       dp_nxt;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign slot_end  = (tick == TICK_LAST);
   assign frame_end = slot_end && (digit == 2'd3);
   assign in_blank  = (tick < BLANK_TICK);
   assign nibble    = shown[{digit, 2'b00} +: 4];

   // Slot timer and digit selector. The digit advances when the slot timer wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick  <= '0;
         digit <= '0;
      end else if (slot_end) begin
         tick  <= '0;
         digit <= digit + 2'd1;
      end else begin
         tick  <= tick + 1'b1;
      end
   end

   // Shadow capture on load, and commit to the displayed copy at the frame boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow  <= '0;
         shown   <= '0;
         pending <= 1'b0;
      end else begin
         // NOTE: non-blocking assignment is what makes a load on the commit edge
         // safe. 'shown' takes the shadow value from before this edge, and the
         // later 'pending <= 1' overrides the clear, so the new value waits a frame.
         if (frame_end && pending) begin
            shown   <= shadow;
            pending <= 1'b0;
         end
         if (bus.load) begin
            shadow  <= bus.value;
            pending <= 1'b1;
         end
      end
   end

   // Leading-zero suppression. A digit is blank when it and every digit above it are zero.
   always_comb begin
      lz_blank = 1'b0;
      if (BLANK_LZ != 0) begin
         unique case (digit)
            2'd1:    lz_blank = (shown[15:4]  == 12'h000);
            2'd2:    lz_blank = (shown[15:8]  == 8'h00);
            2'd3:    lz_blank = (shown[15:12] == 4'h0);
            default: lz_blank = 1'b0;
         endcase
      end
   end

   // Next drive for the output register. Exactly one anode goes low, and only outside the blank window.
   always_comb begin
      // NOTE: every output gets a default before any branch, so no latch is inferred.
      an_nxt  = 4'b1111;
      bcd_nxt = SEG_OFF;
      dp_nxt  = 1'b1;
      if (!in_blank) begin
         an_nxt[digit] = 1'b0;
         bcd_nxt       = lz_blank ? SEG_OFF : hex_to_seg(nibble);
         dp_nxt        = ~bus.dp_en[digit];
      end
   end

   // Registered pin drives. Reset turns every segment off without waiting for a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.AN  <= 4'b1111;
         bus.BCD <= SEG_OFF;
         bus.DP  <= 1'b1;
      end else begin
         bus.AN  <= an_nxt;
         bus.BCD <= bcd_nxt;
         bus.DP  <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display with SCAN_DIV=4, BLANK_CYC=1 and BLANK_LZ=1.
// The stimulus counts clock edges from reset release. At the start of each
// frame it queues the hand-decoded drive expected for each lit slot. A monitor
// takes one entry from the queue at the first lit cycle of each slot and
// compares it on every lit cycle of that slot. The monitor also checks the
// blank and lit run lengths, the blank drive values and that at most one
// anode is low.
module tb_seg7_scan_display;

   localparam int LIT_LEN   = 3;  // SCAN_DIV - BLANK_CYC
   localparam int BLANK_LEN = 1;

   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SA = 7'b0001000;
   localparam logic [6:0] SB = 7'b0000011;
   localparam logic [6:0] SC = 7'b1000110;
   localparam logic [6:0] SF = 7'b0001110;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] bcd;
      logic       dp;
   } exp_t;

   logic clk;
   logic reset;
   logic mon_en;
   int   n_cmp;
   int   n_fail;
   int   edge_n;
   exp_t exp_q[$];

   seg7_scan_if bus ();

   seg7_scan_display #(
      .SCAN_DIV (4),
      .BLANK_CYC(1),
      .BLANK_LZ (1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to 1 time unit after edge n, counted from reset release.
   task automatic advance_to(input int n);
      while (edge_n < n) begin
         @(posedge clk);
         #1;
         edge_n++;
      end
   endtask

   // Hold load high so that it is sampled on edge n only.
   task automatic do_load(input logic [15:0] val, input int n);
      advance_to(n - 1);
      bus.value = val;
      bus.load  = 1'b1;
      advance_to(n);
      bus.load  = 1'b0;
   endtask

   // Queue the expected drive for the first nslots digit slots of one frame.
   task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dpe, input int nslots);
      logic [6:0] segs [4];
      exp_t       e;
      segs = '{s0, s1, s2, s3};
      for (int d = 0; d < nslots; d++) begin
         e.an  = ~(4'b0001 << d);
         e.bcd = segs[d];
         e.dp  = ~dpe[d];
         exp_q.push_back(e);
      end
   endtask

   // Monitor: scoreboard comparison, run-length checks and anode checks on each falling edge.
   initial begin
      logic prev_lit;
      logic lit;
      logic run_valid;
      logic have_exp;
      int   run_len;
      exp_t cur;
      prev_lit  = 1'b0;
      run_valid = 1'b0;
      have_exp  = 1'b0;
      run_len   = 0;
      cur       = '0;
      forever begin
         @(negedge clk);
         if (reset || !mon_en) begin
            prev_lit  = 1'b0;
            run_valid = 1'b0;
            have_exp  = 1'b0;
            run_len   = 0;
         end else begin
            lit = (bus.AN != 4'b1111);
            check("one_hot_an", {15'd0, ($countones(~bus.AN) <= 1)}, 16'd1);
            if (lit != prev_lit && run_len > 0) begin
               if (run_valid)
                  check(prev_lit ? "lit_run_len" : "blank_run_len", 16'(run_len),
                        prev_lit ? 16'(LIT_LEN) : 16'(BLANK_LEN));
               run_valid = 1'b1;
               run_len   = 0;
            end
            run_len++;
            if (!lit) begin
               check("blank_bcd", {9'd0, bus.BCD}, {9'd0, SEG_OFF});
               check("blank_dp", {15'd0, bus.DP}, 16'd1);
            end else begin
               if (!prev_lit) begin
                  if (exp_q.size() == 0) begin
                     n_cmp++;
                     n_fail++;
                     have_exp = 1'b0;
                     $display("FAIL unexpected_slot: got AN=%b, expected no lit slot (t=%0t)",
                              bus.AN, $time);
                  end else begin
                     cur      = exp_q.pop_front();
                     have_exp = 1'b1;
                  end
               end
               if (have_exp) begin
                  check("slot_an", {12'd0, bus.AN}, {12'd0, cur.an});
                  check("slot_bcd", {9'd0, bus.BCD}, {9'd0, cur.bcd});
                  check("slot_dp", {15'd0, bus.DP}, {15'd0, cur.dp});
               end
            end
            prev_lit = lit;
         end
      end
   end

   // Stimulus: directed loads and frame expectations, timed by edge count.
   initial begin
      n_cmp     = 0;
      n_fail    = 0;
      edge_n    = 0;
      mon_en    = 1'b1;
      reset     = 1'b1;
      bus.value = 16'h0000;
      bus.load  = 1'b0;
      bus.dp_en = 4'b0000;

      // Drive values held while reset is asserted.
      #2;
      check("reset_an", {12'd0, bus.AN}, 16'h000F);
      check("reset_bcd", {9'd0, bus.BCD}, {9'd0, SEG_OFF});
      check("reset_dp", {15'd0, bus.DP}, 16'd1);
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      edge_n = 0;

      // Frame 0: nothing loaded. Only digit 0 shows a '0'.
      push_frame(S0, SEG_OFF, SEG_OFF, SEG_OFF, 4'b0000, 4);
      do_load(16'h1234, 5);

      // Frame 1: shows 1234. Two loads are then issued in this frame, and the last one wins.
      advance_to(16);
      push_frame(S4, S3, S2, S1, 4'b0000, 4);
      do_load(16'hABCD, 21);
      do_load(16'h00F0, 25);

      // Frame 2: shows 00F0. ABCD must never appear.
      advance_to(32);
      push_frame(S0, SF, SEG_OFF, SEG_OFF, 4'b0000, 4);
      do_load(16'h5678, 40);
      do_load(16'h9ABC, 48);

      // Frame 3: the shadow from before the commit edge (5678) is shown.
      push_frame(S8, S7, S6, S5, 4'b0000, 4);

      // Frame 4: the value loaded on the commit edge (9ABC) is shown one frame later.
      advance_to(64);
      push_frame(SC, SB, SA, S9, 4'b0000, 4);
      do_load(16'h0007, 70);

      // Frame 5: 0007 is shown, and the decimal point is lit on blank digit 2.
      advance_to(80);
      bus.dp_en = 4'b0100;
      push_frame(S7, SEG_OFF, SEG_OFF, SEG_OFF, 4'b0100, 4);

      // Frame 6: a load is left pending, then reset hits during the lit phase of digit 2.
      advance_to(96);
      push_frame(S7, SEG_OFF, SEG_OFF, SEG_OFF, 4'b0100, 3);
      do_load(16'hBEEF, 100);
      advance_to(107);
      reset = 1'b1;
      #1;
      check("async_reset_an", {12'd0, bus.AN}, 16'h000F);
      check("async_reset_bcd", {9'd0, bus.BCD}, {9'd0, SEG_OFF});
      check("async_reset_dp", {15'd0, bus.DP}, 16'd1);
      bus.dp_en = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      edge_n = 0;

      // After reset, the scan restarts at digit 0 showing 0, and BEEF never commits.
      push_frame(S0, SEG_OFF, SEG_OFF, SEG_OFF, 4'b0000, 4);
      advance_to(16);
      push_frame(S0, SEG_OFF, SEG_OFF, SEG_OFF, 4'b0000, 4);
      advance_to(32);
      mon_en = 1'b0;
      check("queue_drained", 16'(exp_q.size()), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
